preg_freelist_ctrl: RTL and testbench

Physical-register allocation controller for the rename stage. Owns a bitmap of free physical tags, hands the lowest free tag to rename each cycle, and accepts tags returned at retire. On FLUSH it sequences a multi-cycle rebuild of the free set from the committed (RRAT) map, and holds rename off until the rebuild finishes.

---
 rtl/rename_pkg.sv | 17 +
 rtl/prio_enc_lsb.sv | 21 ++
 rtl/preg_freelist_ctrl.sv | 107 ++++++++++
 tb/tb_preg_freelist_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// rtl/rename_pkg.sv - shared rename-stage sizes, tag type and free-list states
package rename_pkg;

  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int PTAG_W    = $clog2(NUM_PREGS);
  localparam int WIDX_W    = $clog2(NUM_AREGS);

  typedef logic [PTAG_W-1:0] ptag_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REC_CLR  = 2'd1,
    REC_WALK = 2'd2
  } fl_state_t;

endpackage

// File: rtl/prio_enc_lsb.sv
// rtl/prio_enc_lsb.sv - lowest-set-bit priority encoder with valid flag
module prio_enc_lsb #(
  parameter int W     = 64,
  parameter int IDX_W = $clog2(W)
) (
  input  logic [W-1:0]     req_vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scanning from the top down lets the lowest set bit overwrite last.
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req_vec[i]) idx = IDX_W'(i);
    end
  end

  assign valid = |req_vec;

endmodule

// File: rtl/preg_freelist_ctrl.sv
// rtl/preg_freelist_ctrl.sv - physical tag free list with flush rebuild from RRAT
// Optional FREELIST_CHECK_EN: sticky double-free flag and empty-fire assertion.
module preg_freelist_ctrl
  import rename_pkg::*;
(
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        FLUSH,
  input  logic                        STALL,
  input  logic                        alloc_req,
  output logic                        alloc_ready,
  output logic [PTAG_W-1:0]           alloc_tag,
  input  logic                        free_valid,
  input  logic [PTAG_W-1:0]           free_tag,
  input  logic [NUM_AREGS*PTAG_W-1:0] rrat_map,
  output logic                        recovering,
  output logic [PTAG_W:0]             free_count,
  output logic                        err_double_free
);

  fl_state_t              state, state_n;
  logic [NUM_PREGS-1:0]   free_bm, free_bm_n;
  logic [PTAG_W:0]        count_n;
  logic [WIDX_W-1:0]      widx, widx_n;
  logic                   enc_valid;
  logic                   fire;
  logic                   free_ok;
  logic                   double_free;
  logic                   free_inc;
  logic [PTAG_W-1:0]      walk_tag;

  prio_enc_lsb #(.W(NUM_PREGS), .IDX_W(PTAG_W)) u_enc (
    .req_vec (free_bm),
    .idx     (alloc_tag),
    .valid   (enc_valid)
  );

  assign recovering  = (state != RUN);
  assign alloc_ready = (state == RUN) && enc_valid && (free_count != '0) && !FLUSH;
  assign fire        = alloc_req && alloc_ready && !STALL;
  assign free_ok     = (state == RUN) && !FLUSH && free_valid;
  // A tag returned in the same cycle it is granted was free only until this edge.
  assign double_free = free_ok && free_bm[free_tag] && !(fire && (alloc_tag == free_tag));
  assign free_inc    = free_ok && !double_free;
  assign walk_tag    = rrat_map[int'(widx)*PTAG_W +: PTAG_W];

  always_comb begin
    state_n   = state;
    free_bm_n = free_bm;
    count_n   = free_count;
    widx_n    = widx;
    if (FLUSH) begin
      state_n = REC_CLR;
    end else begin
      case (state)
        RUN: begin
          if (fire)    free_bm_n[alloc_tag] = 1'b0;
          if (free_ok) free_bm_n[free_tag]  = 1'b1;
          count_n = free_count - (PTAG_W+1)'(fire) + (PTAG_W+1)'(free_inc);
        end
        REC_CLR: begin
          free_bm_n = '1;
          count_n   = (PTAG_W+1)'(NUM_PREGS);
          widx_n    = '0;
          state_n   = REC_WALK;
        end
        REC_WALK: begin
          // Duplicate RRAT entries hit an already-cleared bit and are not recounted.
          if (free_bm[walk_tag]) begin
            free_bm_n[walk_tag] = 1'b0;
            count_n             = free_count - (PTAG_W+1)'(1);
          end
          widx_n = widx + WIDX_W'(1);
          if (widx == WIDX_W'(NUM_AREGS - 1)) state_n = RUN;
        end
        default: state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= RUN;
      free_bm    <= {{(NUM_PREGS-NUM_AREGS){1'b1}}, {NUM_AREGS{1'b0}}};
      free_count <= (PTAG_W+1)'(NUM_PREGS - NUM_AREGS);
      widx       <= '0;
    end else begin
      state      <= state_n;
      free_bm    <= free_bm_n;
      free_count <= count_n;
      widx       <= widx_n;
    end
  end

`ifdef FREELIST_CHECK_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) err_double_free <= 1'b0;
    else if (double_free) err_double_free <= 1'b1;
  end

  a_no_fire_when_empty: assert property (@(posedge CLK) disable iff (!RESET)
    !(fire && (free_count == '0)));
`else
  assign err_double_free = 1'b0;
`endif

endmodule

// File: tb/tb_preg_freelist_ctrl.sv
// tb/tb_preg_freelist_ctrl.sv - randomized and directed bench against a free-set reference model
module tb_preg_freelist_ctrl;
  import rename_pkg::*;

  logic                        CLK = 1'b0;
  logic                        RESET = 1'b0;
  logic                        FLUSH = 1'b0;
  logic                        STALL = 1'b0;
  logic                        alloc_req = 1'b0;
  logic                        alloc_ready;
  logic [PTAG_W-1:0]           alloc_tag;
  logic                        free_valid = 1'b0;
  logic [PTAG_W-1:0]           free_tag = '0;
  logic [NUM_AREGS*PTAG_W-1:0] rrat_map = '0;
  logic                        recovering;
  logic [PTAG_W:0]             free_count;
  logic                        err_double_free;

  always #5 CLK = ~CLK;

  preg_freelist_ctrl dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .FLUSH           (FLUSH),
    .STALL           (STALL),
    .alloc_req       (alloc_req),
    .alloc_ready     (alloc_ready),
    .alloc_tag       (alloc_tag),
    .free_valid      (free_valid),
    .free_tag        (free_tag),
    .rrat_map        (rrat_map),
    .recovering      (recovering),
    .free_count      (free_count),
    .err_double_free (err_double_free)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: a set of free tags, a recovery countdown and a sticky error bit.
  bit m_free[NUM_PREGS];
  int m_rec;
  bit m_err;
  bit last_rec;

`ifdef FREELIST_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < NUM_PREGS; i++) n += int'(m_free[i]);
    return n;
  endfunction

  function automatic int m_lowest();
    for (int i = 0; i < NUM_PREGS; i++) if (m_free[i]) return i;
    return -1;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NUM_PREGS; i++) m_free[i] = (i >= NUM_AREGS);
    m_rec = 0;
    m_err = 1'b0;
  endfunction

  function automatic void m_rebuild();
    for (int i = 0; i < NUM_PREGS; i++) m_free[i] = 1'b1;
    for (int a = 0; a < NUM_AREGS; a++) m_free[int'(rrat_map[a*PTAG_W +: PTAG_W])] = 1'b0;
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b0; FLUSH = 1'b0; STALL = 1'b0; alloc_req = 1'b0; free_valid = 1'b0;
    #1;
    m_reset();
    check("rst_recovering", recovering, 0);
    check("rst_count", free_count, NUM_PREGS - NUM_AREGS);
    check("rst_err", err_double_free, 0);
    check("rst_ready", alloc_ready, 1);
    check("rst_tag", alloc_tag, NUM_AREGS);
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic step(input bit flush, input bit stall, input bit req, input bit fv, input int ft);
    bit exp_ready;
    bit fire;
    int low;
    @(negedge CLK);
    FLUSH = flush; STALL = stall; alloc_req = req; free_valid = fv; free_tag = PTAG_W'(ft);
    #1;
    low       = m_lowest();
    exp_ready = (m_rec == 0) && (m_count() > 0) && !flush;
    last_rec  = recovering;
    check("recovering", recovering, (m_rec != 0));
    check("alloc_ready", alloc_ready, exp_ready);
    if (exp_ready) check("alloc_tag", alloc_tag, low);
    if (m_rec == 0) check("free_count", free_count, m_count());
    check("err_double_free", err_double_free, m_err);
    if (flush) begin
      m_rec = 1 + NUM_AREGS;
    end else if (m_rec > 0) begin
      m_rec--;
      if (m_rec == 0) m_rebuild();
    end else begin
      fire = req && exp_ready && !stall;
      if (fv && m_free[ft] && !(fire && ft == low) && CHECK_EN) m_err = 1'b1;
      if (fire) m_free[low] = 1'b0;
      if (fv) m_free[ft] = 1'b1;
    end
  endtask

  task automatic count_recovery(input string tag);
    int n = 0;
    for (int k = 0; k < 40; k++) begin
      step(0, 0, 0, 0, 0);
      if (last_rec) n++;
    end
    check(tag, n, 1 + NUM_AREGS);
  endtask

  initial begin
    do_reset();

    for (int k = 0; k < NUM_PREGS - NUM_AREGS; k++) step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check("empty_ready", alloc_ready, 0);
    check("empty_count", free_count, 0);

    step(0, 0, 1, 1, 40);
    step(0, 0, 0, 0, 0);
    check("refill_tag", alloc_tag, 40);
    check("refill_count", free_count, 1);

    for (int t = 10; t < 14; t++) step(0, 0, 0, 1, t);
    step(0, 0, 1, 1, 7);
    step(0, 0, 0, 0, 0);
    check("fire_free_count", free_count, 5);
    check("late_grant_tag", alloc_tag, 7);

    for (int a = 0; a < NUM_AREGS; a++) rrat_map[a*PTAG_W +: PTAG_W] = PTAG_W'(a + NUM_AREGS);
    step(1, 0, 1, 1, 3);
    count_recovery("rec_len");
    check("post_rec_count", free_count, NUM_AREGS);
    check("post_rec_tag", alloc_tag, 0);

    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 11; k++) step(0, 0, 1, 1, 60);
    step(1, 0, 0, 0, 0);
    count_recovery("rec_restart_len");
    check("restart_count", free_count, NUM_AREGS);
    check("restart_tag", alloc_tag, 0);

    step(0, 0, 0, 1, 50);
    step(0, 0, 0, 1, 50);
    step(0, 0, 0, 0, 0);
    check("dbl_free_count", free_count, NUM_AREGS + 1);
    check("dbl_free_flag", err_double_free, CHECK_EN);

    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0);
    do_reset();

    for (int k = 0; k < 3000; k++) begin
      if (m_rec == 0 && $urandom_range(0, 99) < 3) begin
        for (int a = 0; a < NUM_AREGS; a++)
          rrat_map[a*PTAG_W +: PTAG_W] = PTAG_W'($urandom_range(0, NUM_PREGS - 1));
      end
      step($urandom_range(0, 99) < 2, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, int'($urandom_range(0, NUM_PREGS - 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
